// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue front-end: opcode width, indices into
// the captured flag vector {of_und, err, zero}, and the issue FSM states.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W = 4;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_ERR   = 1;
    localparam int FLG_OFUND = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_if
// Bundles every non-clock signal of alu_issue_ctrl:
//   cmd_*   command push handshake (valid/ready) and fields
//   alu_*   registered operands out to the ALU, combinational results back
//   res_*   held result handshake (valid/ready), data and flags
//   err_cnt saturating error count, busy activity indicator
// Modports: slave = the issue controller, master = its environment.
// -----------------------------------------------------------------------------
interface alu_issue_ctrl_if #(
    parameter int W        = 8,
    parameter int ERRCNT_W = 8
);
    import alu_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [W-1:0]        cmd_a;
    logic [W-1:0]        cmd_b;
    logic [OP_W-1:0]     cmd_op;
    logic                cmd_chain;

    logic [W-1:0]        alu_a;
    logic [W-1:0]        alu_b;
    logic [OP_W-1:0]     alu_op;
    logic [W-1:0]        alu_o;
    logic                alu_of_und;
    logic                alu_err;
    logic                alu_zero;

    logic                res_valid;
    logic                res_ready;
    logic [W-1:0]        res_data;
    logic [2:0]          res_flags;

    logic [ERRCNT_W-1:0] err_cnt;
    logic                busy;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_o, alu_of_und, alu_err, alu_zero,
        output res_valid, res_data, res_flags,
        input  res_ready,
        output err_cnt, busy
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_o, alu_of_und, alu_err, alu_zero,
        input  res_valid, res_data, res_flags,
        output res_ready,
        input  err_cnt, busy
    );

endinterface

// File: rtl/alu_issue_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous FIFO, WIDTH bits x DEPTH entries (DEPTH power of two, >= 2).
// Ports: clk, rst (async high), i_push/i_data, i_pop/o_data (head, show-ahead),
//        o_full, o_empty. Push while full and pop while empty are ignored.
// Pointers carry one extra bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wp, r_rp;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push, w_pop;

    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + (AW+1)'(1);
            if (w_pop)  r_rp <= r_rp + (AW+1)'(1);
        end
    end

    // Storage needs no reset: empty pointers hide stale contents.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Command front-end for a combinational ALU. Commands are queued in
// alu_cmd_fifo, issued one at a time through registered alu_a/alu_b/alu_op,
// and the ALU result plus flags are captured into a held res_* handshake.
// Ports: clk, rst (async high), bus (alu_issue_ctrl_if.slave).
// Parameters: W data width, DEPTH FIFO depth, ERRCNT_W err_cnt width.
// Optional feature macro ALU_ISSUE_CHAIN_EN: keeps an accumulator of the last
// captured result; a command with cmd_chain=1 takes its A operand from it.
// -----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int W        = 8,
    parameter int DEPTH    = 4,
    parameter int ERRCNT_W = 8
) (
    input logic                clk,
    input logic                rst,
    alu_issue_ctrl_if.slave    bus
);
`ifdef ALU_ISSUE_CHAIN_EN
    localparam int FW = 1 + OP_W + 2*W;
`else
    localparam int FW = OP_W + 2*W;
`endif

    issue_state_t        r_state;
    logic [W-1:0]        r_alu_a, r_alu_b;
    logic [OP_W-1:0]     r_alu_op;
    logic                r_res_valid;
    logic [W-1:0]        r_res_data;
    logic [2:0]          r_res_flags;
    logic [ERRCNT_W-1:0] r_err_cnt;

    logic [FW-1:0]       w_wdata, w_head;
    logic                w_full, w_empty, w_pop, w_accept;
    logic [W-1:0]        w_next_a;

`ifdef ALU_ISSUE_CHAIN_EN
    logic [W-1:0]        r_acc;
    assign w_wdata  = {bus.cmd_chain, bus.cmd_op, bus.cmd_b, bus.cmd_a};
    assign w_next_a = w_head[FW-1] ? r_acc : w_head[W-1:0];
`else
    logic w_unused_chain;
    assign w_unused_chain = bus.cmd_chain;
    assign w_wdata  = {bus.cmd_op, bus.cmd_b, bus.cmd_a};
    assign w_next_a = w_head[W-1:0];
`endif

    assign w_accept = r_res_valid && bus.res_ready;
    // Pop whenever the FSM is about to (re)load the ALU registers.
    assign w_pop    = !w_empty && ((r_state == IDLE) || (r_state == HOLD && w_accept));

    alu_cmd_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.cmd_valid),
        .i_data  (w_wdata),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_flags <= '0;
            r_err_cnt   <= '0;
`ifdef ALU_ISSUE_CHAIN_EN
            r_acc       <= '0;
`endif
        end else begin
            if (w_pop) begin
                r_alu_a  <= w_next_a;
                r_alu_b  <= w_head[2*W-1:W];
                r_alu_op <= w_head[2*W+OP_W-1:2*W];
            end
            case (r_state)
                IDLE: if (w_pop) r_state <= EXEC;
                EXEC: begin
                    r_res_data             <= bus.alu_o;
                    r_res_flags[FLG_OFUND] <= bus.alu_of_und;
                    r_res_flags[FLG_ERR]   <= bus.alu_err;
                    r_res_flags[FLG_ZERO]  <= bus.alu_zero;
                    r_res_valid            <= 1'b1;
                    if (bus.alu_err && (r_err_cnt != {ERRCNT_W{1'b1}}))
                        r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
`ifdef ALU_ISSUE_CHAIN_EN
                    r_acc                  <= bus.alu_o;
`endif
                    r_state                <= HOLD;
                end
                HOLD: if (w_accept) begin
                    r_res_valid <= 1'b0;
                    r_state     <= w_pop ? EXEC : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = !w_full;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_op    = r_alu_op;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_flags = r_res_flags;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.busy      = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl with a small behavioural ALU attached.
// ALU model: op0 add (of_und=carry), op1 sub (of_und=borrow), op2 and,
// op3 or, op4 xor, any other op -> err=1, result 0. zero = (result == 0).
// Expected results are queued at push time; a negedge monitor pops and
// compares on every res_valid && res_ready.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;
    localparam int W = 8;
    localparam int DEPTH = 4;
    localparam int ERRCNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.W(W), .ERRCNT_W(ERRCNT_W)) bus();

    alu_issue_ctrl #(.W(W), .DEPTH(DEPTH), .ERRCNT_W(ERRCNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // behavioural ALU
    always_comb begin
        logic [W:0] t;
        t              = '0;
        bus.alu_o      = '0;
        bus.alu_of_und = 1'b0;
        bus.alu_err    = 1'b0;
        case (bus.alu_op)
            4'd0: begin t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}; bus.alu_o = t[W-1:0]; bus.alu_of_und = t[W]; end
            4'd1: begin bus.alu_o = bus.alu_a - bus.alu_b; bus.alu_of_und = (bus.alu_a < bus.alu_b); end
            4'd2: bus.alu_o = bus.alu_a & bus.alu_b;
            4'd3: bus.alu_o = bus.alu_a | bus.alu_b;
            4'd4: bus.alu_o = bus.alu_a ^ bus.alu_b;
            default: bus.alu_err = 1'b1;
        endcase
        bus.alu_zero = (bus.alu_o == '0);
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [10:0] exp_q[$];
    logic drain_mode = 1'b0;
    int prev_acc = -1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expire(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                expire("unexpected_result");
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check("res_data", {24'd0, bus.res_data}, {24'd0, e[10:3]});
                check("res_flags", {29'd0, bus.res_flags}, {29'd0, e[2:0]});
            end
            if (drain_mode) begin
                if (prev_acc >= 0) check("drain_spacing", cyc - prev_acc, 2);
                prev_acc = cyc;
            end
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic chain, input logic [7:0] ed, input logic [2:0] ef);
        int n = 0;
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_chain = chain;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) expire("push_wait");
        else exp_q.push_back({ed, ef});
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 2000) begin @(posedge clk); #1; n++; end
        if (n >= 2000) expire(name);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
        bus.cmd_chain = 1'b0; bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err_cnt", bus.err_cnt, 0);

        // latency: push at edge k, ALU regs at k+1, res_valid at k+2
        push(8'd5, 8'd10, 4'd0, 1'b0, 8'd15, 3'b000);
        check("lat_k_valid", bus.res_valid, 0);
        step();
        check("lat_k1_valid", bus.res_valid, 0);
        check("lat_k1_alu_a", bus.alu_a, 5);
        check("lat_k1_alu_b", bus.alu_b, 10);
        step();
        check("lat_k2_valid", bus.res_valid, 1);
        wait_idle("lat_drain");

        // overflow and assorted ops
        push(8'd200, 8'd200, 4'd0, 1'b0, 8'd144, 3'b100);
        push(8'd3,   8'd5,   4'd1, 1'b0, 8'd254, 3'b100);
        push(8'hF0,  8'h0F,  4'd2, 1'b0, 8'h00,  3'b001);
        push(8'hAA,  8'h55,  4'd4, 1'b0, 8'hFF,  3'b000);
        push(8'h81,  8'h18,  4'd3, 1'b0, 8'h99,  3'b000);
        wait_idle("ops_drain");
        check("ops_alu_op_hold", bus.alu_op, 3);

        // fill: one in flight plus DEPTH queued, then drain in order
        bus.res_ready = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++)
            push(8'(i), 8'(i), 4'd0, 1'b0, 8'(2*i), 3'b000);
        check("full_cmd_ready", bus.cmd_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_valid", bus.res_valid, 1);
            check("hold_data", bus.res_data, 2);
        end
        prev_acc = -1;
        drain_mode = 1'b1;
        bus.res_ready = 1'b1;
        wait_idle("full_drain");
        drain_mode = 1'b0;
        check("full_cmd_ready_after", bus.cmd_ready, 1);

        // error counter saturation
        for (int i = 0; i < 3; i++) push(8'd1, 8'd2, 4'd15, 1'b0, 8'd0, 3'b011);
        wait_idle("err3_drain");
        check("err_cnt_3", bus.err_cnt, 3);
        for (int i = 0; i < (1 << ERRCNT_W) - 2; i++) push(8'd1, 8'd2, 4'd15, 1'b0, 8'd0, 3'b011);
        wait_idle("err_sat_drain");
        check("err_cnt_sat", bus.err_cnt, 255);

        // async reset during HOLD with 2 queued
        bus.res_ready = 1'b0;
        push(8'd7, 8'd1, 4'd1, 1'b0, 8'd6, 3'b000);
        push(8'd9, 8'd9, 4'd1, 1'b0, 8'd0, 3'b001);
        push(8'd1, 8'd2, 4'd0, 1'b0, 8'd3, 3'b000);
        begin
            int n = 0;
            while (!bus.res_valid && n < 20) begin step(); n++; end
            if (n >= 20) expire("hold_wait");
        end
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_res_valid", bus.res_valid, 0);
        check("arst_res_data", bus.res_data, 0);
        check("arst_res_flags", bus.res_flags, 0);
        check("arst_alu_a", bus.alu_a, 0);
        check("arst_alu_b", bus.alu_b, 0);
        check("arst_alu_op", bus.alu_op, 0);
        check("arst_err_cnt", bus.err_cnt, 0);
        check("arst_busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("arst_cmd_ready", bus.cmd_ready, 1);
        bus.res_ready = 1'b1;
        repeat (8) step();
        check("arst_no_stale_valid", bus.res_valid, 0);
        check("arst_no_stale_busy", bus.busy, 0);

        // chaining
        push(8'd5, 8'd10, 4'd0, 1'b0, 8'd15, 3'b000);
`ifdef ALU_ISSUE_CHAIN_EN
        push(8'd0, 8'd1, 4'd0, 1'b1, 8'd16, 3'b000);
`else
        push(8'd0, 8'd1, 4'd0, 1'b1, 8'd1, 3'b000);
`endif
        wait_idle("chain_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
